// File: rtl/gate_prober.sv
// Sweeps {a,b}=00..11 onto a 2-input gate, captures its truth table and decodes the gate function.
// Latency: start edge to done = 4*(SETTLE_CYCLES+1)+1 cycles. A start while busy is dropped, not queued.
module gate_prober #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       probe_a,
  output logic       probe_b,
  input  logic       probe_y,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [3:0] gate_code
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DECODE,
    S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;

  // The vector index register drives the probes directly, so they are registered.
  assign probe_a = idx[1];
  assign probe_b = idx[0];

  function automatic logic [3:0] decode(input logic [3:0] tt);
    logic [3:0] code;
    case (tt)
      4'b1000: code = 4'd1;
      4'b0111: code = 4'd2;
      4'b1110: code = 4'd3;
      4'b0001: code = 4'd4;
      4'b0110: code = 4'd5;
      4'b1001: code = 4'd6;
      4'b0011: code = 4'd7;
      4'b1100: code = 4'd8;
      4'b0101: code = 4'd9;
      4'b1010: code = 4'd10;
      4'b0000: code = 4'd11;
      4'b1111: code = 4'd12;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 4'd0;
      gate_code   <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state       <= S_SWEEP;
            busy        <= 1'b1;
            idx         <= 2'd0;
            cnt         <= '0;
            truth_table <= 4'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SWEEP: begin
          // Capture on the edge that ends the last settle cycle of this vector.
          if (cnt == SETTLE_LAST) begin
            truth_table[idx] <= probe_y;
            cnt              <= '0;
            if (idx == 2'd3) begin
              state <= S_DECODE;
              idx   <= 2'd0;
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          gate_code <= decode(truth_table);
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_prober.sv
// Scoreboard bench for gate_prober: SETTLE_CYCLES=2 and SETTLE_CYCLES=0 instances probing a modelled gate.
module tb_gate_prober;

  typedef struct {
    logic [3:0] tt;
    logic [3:0] code;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  int         dup_kind = 0;

  logic       a0, b0, y0, busy0, done0;
  logic       a1, b1, y1, busy1, done1;
  logic [3:0] tt0, code0, tt1, code1;
  logic       start0, start1;
  logic       a_m, b_m, busy_m, done_m;
  logic [3:0] tt_m, code_m;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  // 0 nand, 1 xor, 2 xnor, 3 a&~b, 4 constant 1
  function automatic logic dup_fn(input int kind, input logic a, input logic b);
    case (kind)
      0:       return ~(a & b);
      1:       return a ^ b;
      2:       return ~(a ^ b);
      3:       return a & ~b;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    y0     = dup_fn(dup_kind, a0, b0);
    y1     = dup_fn(dup_kind, a1, b1);
    start0 = start & ~sel;
    start1 = start & sel;
    a_m    = sel ? a1 : a0;
    b_m    = sel ? b1 : b0;
    busy_m = sel ? busy1 : busy0;
    done_m = sel ? done1 : done0;
    tt_m   = sel ? tt1 : tt0;
    code_m = sel ? code1 : code0;
  end

  gate_prober #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .probe_a(a0), .probe_b(b0), .probe_y(y0),
    .busy(busy0), .done(done0), .truth_table(tt0), .gate_code(code0)
  );

  gate_prober #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .probe_a(a1), .probe_b(b1), .probe_y(y1),
    .busy(busy1), .done(done1), .truth_table(tt1), .gate_code(code1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sweep on the selected instance; optional start re-pulse while busy,
  // optional start held into the DONE cycle for a back-to-back sweep.
  task automatic sweep(input int kind, input logic [3:0] e_tt, input logic [3:0] e_code,
                       input bit repulse, input bit b2b);
    int          s1, lat, cmax;
    exp_t        e;
    logic [23:0] seq, eseq;
    s1       = sel ? 1 : 3;
    lat      = 4 * s1 + 1;
    dup_kind = kind;
    seq      = '0;
    eseq     = '0;
    sbq.push_back('{e_tt, e_code, lat});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy_m, 1);
    cmax = b2b ? 2 * lat + 6 : lat + 6;
    for (int c = 0; c <= cmax; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c < 4 * s1) begin
        seq  = {seq[21:0], a_m, b_m};
        eseq = {eseq[21:0], 2'(c / s1)};
      end
      if (done_m) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", c, 0);
        end else begin
          e = sbq.pop_front();
          chk("truth_table", tt_m, e.tt);
          chk("gate_code", code_m, e.code);
          chk("latency", c, e.due);
          chk("busy_in_done", busy_m, 0);
        end
      end
      start = (repulse && c == 4) || (b2b && c == lat);
      if (b2b && c == lat) sbq.push_back('{e_tt, e_code, 2 * lat + 1});
    end
    start = 1'b0;
    chk("probe_sequence", seq, eseq);
    chk("missing_done", sbq.size(), 0);
    sbq.delete();
    chk("result_held", tt_m, e_tt);
    chk("probes_idle", {a_m, b_m}, 2'b00);
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {busy0, busy1}, 2'b00);
    chk("rst_done", {done0, done1}, 2'b00);
    chk("rst_probes", {a0, b0, a1, b1}, 4'b0000);
    chk("rst_results", {tt0, code0, tt1, code1}, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    sel = 1'b0;
    sweep(0, 4'b0111, 4'd2, 1'b0, 1'b0);
    sweep(1, 4'b0110, 4'd5, 1'b0, 1'b0);
    sweep(2, 4'b1001, 4'd6, 1'b0, 1'b0);
    sweep(3, 4'b0100, 4'd0, 1'b0, 1'b0);
    sweep(0, 4'b0111, 4'd2, 1'b1, 1'b0);
    sweep(1, 4'b0110, 4'd5, 1'b0, 1'b1);
    sweep(0, 4'b0111, 4'd2, 1'b0, 1'b0);

    // Abort mid-sweep with reset as vector 2 is being driven.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && !(a_m && !b_m); c++) begin
      @(posedge clk); #1;
    end
    chk("reached_vector2", {a_m, b_m}, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy_m, 0);
    chk("abort_done", done_m, 0);
    chk("abort_probes", {a_m, b_m}, 2'b00);
    chk("abort_results", {tt_m, code_m}, 8'h00);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (done_m || busy_m) ndone++;
    end
    chk("idle_after_abort", ndone, 0);
    sweep(2, 4'b1001, 4'd6, 1'b0, 1'b0);

    sel = 1'b1;
    sweep(4, 4'b1111, 4'd12, 1'b0, 1'b0);
    sweep(1, 4'b0110, 4'd5, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
